// File: rtl/ram16x8_pkg.sv
// Shared types and widths for the 16x8 RAM tester.
package ram16x8_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 2 * DEF_ADDR_W;
    localparam int ERR_W      = 6;

endpackage

// File: rtl/ram_test_pattern.sv
// Test data generator: {addr, ~addr}, fully inverted on the second pass.
module ram_test_pattern #(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic                inv,
    output logic [2*ADDR_W-1:0] data
);

    assign data = {addr, ~addr} ^ {(2*ADDR_W){inv}};

endmodule

// File: rtl/ram16x8_tester.sv
// Write/read-back tester for a RAM with one-cycle registered read data.
// Define RAM16X8_TESTER_INV_PASS_EN to add a second, inverted-pattern pass.
module ram16x8_tester
    import ram16x8_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [2:0]        fsm_state
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_vld_q;
    logic              pass_idx;
    logic [DATA_W-1:0] din_pat;
    logic [DATA_W-1:0] exp_pat;
    logic              mismatch;
    logic              start_edge;
    logic              last_addr;
    logic [ERR_W-1:0]  err_nx;

    ram_test_pattern #(.ADDR_W(ADDR_W)) u_din_pat (
        .addr (addr_q),
        .inv  (pass_idx),
        .data (din_pat)
    );

    ram_test_pattern #(.ADDR_W(ADDR_W)) u_exp_pat (
        .addr (rd_addr_q),
        .inv  (pass_idx),
        .data (exp_pat)
    );

    assign last_addr  = (addr_q == '1);
    assign start_edge = (state == IDLE) && start;
    // Read data lags the issued address by one cycle, so compare against the delayed address.
    assign mismatch   = rd_vld_q && (ram_dout != exp_pat);
    assign fsm_state  = state;

    always_comb begin
        err_nx = err_cnt;
        if (mismatch && (err_cnt != ERR_MAX)) begin
            err_nx = err_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = WRITE;
            end
            WRITE: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = addr_q;
                ram_din  = din_pat;
                busy     = 1'b1;
                if (last_addr) state_nx = READ;
            end
            READ: begin
                ram_en   = 1'b1;
                ram_addr = addr_q;
                busy     = 1'b1;
                if (last_addr) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
`ifdef RAM16X8_TESTER_INV_PASS_EN
                state_nx = pass_idx ? DONE : WRITE;
`else
                state_nx = DONE;
`endif
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr_q         <= '0;
            rd_addr_q      <= '0;
            rd_vld_q       <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            state     <= state_nx;
            addr_q    <= ((state == WRITE) || (state == READ)) ? addr_q + 1'b1 : '0;
            rd_addr_q <= addr_q;
            rd_vld_q  <= (state == READ);
            if (start_edge) begin
                err_cnt        <= '0;
                first_err_addr <= '0;
            end else begin
                err_cnt <= err_nx;
                if (mismatch && (err_cnt == '0)) first_err_addr <= rd_addr_q;
            end
            // Include the final DRAIN compare in the verdict.
            if ((state == DRAIN) && (state_nx == DONE)) pass <= (err_nx == '0);
        end
    end

`ifdef RAM16X8_TESTER_INV_PASS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_idx <= 1'b0;
        end else if (start_edge) begin
            pass_idx <= 1'b0;
        end else if (state == DRAIN) begin
            pass_idx <= 1'b1;
        end
    end
`else
    assign pass_idx = 1'b0;
`endif

endmodule

// File: tb/tb_ram16x8_tester.sv
// Randomized bench for ram16x8_tester with a behavioural RAM and fault injection.
module tb_ram16x8_tester;

`ifdef RAM16X8_TESTER_INV_PASS_EN
    localparam int NUM_PASS = 2;
`else
    localparam int NUM_PASS = 1;
`endif
    localparam int RUN_LEN = 33 * NUM_PASS + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ram_en, ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       busy, done, pass;
    logic [5:0] err_cnt;
    logic [3:0] first_err_addr;
    logic [2:0] fsm_state;

    logic       force_b0 = 1'b0;
    logic       cor_on   = 1'b0;
    logic [3:0] cor_addr = 4'd0;
    logic [7:0] cor_mask = 8'd0;
    logic [7:0] mem [16];
    logic [7:0] dout_q = 8'd0;

    int checks = 0;
    int errors = 0;
    logic       prev_pass  = 1'b0;
    logic [5:0] prev_err   = 6'd0;
    logic [3:0] prev_first = 4'd0;

    ram16x8_tester dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, optional stuck bit and corrupted word.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din ^ ((cor_on && ram_addr == cor_addr) ? cor_mask : 8'h00);
            else        dout_q <= mem[ram_addr];
        end
    end
    assign ram_dout = dout_q | {7'd0, force_b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int a, input int p);
        logic [3:0] av;
        av = a[3:0];
        return {av, ~av} ^ ((p != 0) ? 8'hFF : 8'h00);
    endfunction

    // Expected {done, busy, en, we, addr, din} for cycle c after the start-sample edge.
    function automatic logic [15:0] exp_cycle(input int c);
        int p, k;
        if (c == RUN_LEN) return 16'h8000;
        p = (c - 1) / 33;
        k = (c - 1) % 33;
        if (k < 16) return {1'b0, 1'b1, 1'b1, 1'b1, 4'(k), pat(k, p)};
        if (k < 32) return {1'b0, 1'b1, 1'b1, 1'b0, 4'(k - 16), 8'h00};
        return 16'h4000;
    endfunction

    task automatic model(output int e, output int f, output logic [7:0] w5);
        logic [7:0] stored, obs;
        e = 0; f = 0; w5 = 8'h00;
        for (int p = 0; p < NUM_PASS; p++) begin
            for (int a = 0; a < 16; a++) begin
                stored = pat(a, p) ^ ((cor_on && a == int'(cor_addr)) ? cor_mask : 8'h00);
                obs    = stored | {7'd0, force_b0};
                if (obs != pat(a, p)) begin
                    if (e == 0) f = a;
                    e++;
                end
                if (a == 5) w5 = stored;
            end
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {2'd0, fsm_state, done, busy, ram_en, ram_we, ram_addr, ram_din,
                pass, err_cnt, first_err_addr};
    endfunction

    // Called at a negedge with the DUT in IDLE; abort_at > 0 pulls reset mid-run.
    task automatic run(input bit hold, input int abort_at);
        int e, f;
        logic [7:0] w5;
        model(e, f, w5);
        start = 1'b1;
        for (int c = 1; c <= RUN_LEN; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            check("cycle", 32'({done, busy, ram_en, ram_we, ram_addr, ram_din}), 32'(exp_cycle(c)));
            if (c == 1)
                check("clear_on_start", 32'({err_cnt, first_err_addr, pass}), 32'({6'd0, 4'd0, prev_pass}));
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check("async_reset", all_outs(), 32'd0);
                @(negedge clk);
                check("reset_hold", all_outs(), 32'd0);
                rst_n = 1'b1;
                start = 1'b0;
                prev_pass = 1'b0; prev_err = 6'd0; prev_first = 4'd0;
                return;
            end
            if (c == RUN_LEN) begin
                check("pass", 32'(pass), 32'(e == 0));
                check("err_cnt", 32'(err_cnt), 32'(e));
                check("first_err_addr", 32'(first_err_addr), 32'(f));
                check("ram_word5", 32'(mem[5]), 32'(w5));
                prev_pass = (e == 0); prev_err = 6'(e); prev_first = 4'(f);
            end
        end
        @(negedge clk);
        check("idle_after", 32'({done, busy, ram_en, ram_we, ram_addr, ram_din, pass, err_cnt, first_err_addr}),
              32'({16'd0, prev_pass, prev_err, prev_first}));
    endtask

    task automatic set_faults(input bit fb, input bit co, input logic [3:0] ca, input logic [7:0] cm);
        force_b0 = fb; cor_on = co; cor_addr = ca; cor_mask = cm;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_state", all_outs(), 32'd0);

        set_faults(1'b0, 1'b0, 4'd0, 8'h00); run(1'b0, 0);
        set_faults(1'b1, 1'b0, 4'd0, 8'h00); run(1'b0, 0);
        set_faults(1'b0, 1'b1, 4'd9, 8'h01); run(1'b0, 0);
        set_faults(1'b0, 1'b0, 4'd0, 8'h00);
        run(1'b1, 0);
        run(1'b0, 0);
        @(negedge clk);
        set_faults(1'b1, 1'b0, 4'd0, 8'h00); run(1'b0, 20);
        set_faults(1'b0, 1'b0, 4'd0, 8'h00); run(1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 2))
                0:       set_faults(1'b0, 1'b0, 4'd0, 8'h00);
                1:       set_faults(1'b1, 1'b0, 4'd0, 8'h00);
                default: set_faults(1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(1, 255)));
            endcase
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("idle_gap", 32'({busy, done, ram_en}), 32'd0);
            end
            run(1'($urandom_range(0, 1)), 0);
            start = 1'b0;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
